// File: rtl/ddr3_pkg.sv
// Shared DDR3 definitions: command codes, controller states, timing constants and the
// ns-to-cycles conversion.
package ddr3_pkg;

    // {RAS#, CAS#, WE#}
    typedef enum logic [2:0] {
        DDR3_MODE = 3'b000,
        DDR3_REFR = 3'b001,
        DDR3_PREC = 3'b010,
        DDR3_ACTV = 3'b011,
        DDR3_WRIT = 3'b100,
        DDR3_READ = 3'b101,
        DDR3_ZQCL = 3'b110,
        DDR3_NOOP = 3'b111
    } ddr3_cmd_e;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT} ddl_state_e;

    localparam int unsigned DDR3_CL        = 6;
    localparam int unsigned DDR3_CWL       = 6;
    localparam int unsigned DDR3_BL        = 8;
    localparam int unsigned DDR3_TCCD      = 4;
    localparam int unsigned DDR3_TMRD      = 4;
    localparam int unsigned DDR3_TZQCL     = 512;
    localparam logic [3:0]  DDR3_REF_MAXPD = 4'd8;

    // ceil(ns / tCK) with tCK = 1000/freq_mhz, never less than one cycle
    function automatic int unsigned cycles(input int unsigned ns, input int unsigned freq_mhz);
        int unsigned c;
        c = (ns * freq_mhz + 999) / 1000;
        return (c == 0) ? 1 : c;
    endfunction

endpackage

// File: rtl/ddr3_ref_timer.sv
// Refresh interval counter with a saturating count of postponed refreshes.
module ddr3_ref_timer
    import ddr3_pkg::*;
#(
    parameter int unsigned INTERVAL = 780
) (
    input  logic clock,
    input  logic reset,
    input  logic ref_done_i,
    output logic ref_req_o
);

    localparam int unsigned CW   = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);

    logic [CW-1:0] cnt_q;
    logic [3:0]    pend_q;
    logic          tick;

    assign tick      = (cnt_q == LAST);
    assign ref_req_o = (pend_q != 4'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            pend_q <= 4'd0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            // A tick and a completed refresh in the same cycle cancel out
            if (tick && !ref_done_i && pend_q != DDR3_REF_MAXPD) begin
                pend_q <= pend_q + 4'd1;
            end else if (ref_done_i && !tick && pend_q != 4'd0) begin
                pend_q <= pend_q - 4'd1;
            end
        end
    end

endmodule

// File: rtl/ddr3_ddl_cmd.sv
// DDL command acceptor: registers one command per handshake onto the DFI pins and withholds
// ready for the command's timing gap. Optional tFAW check under DDR3_TFAW_EN.
module ddr3_ddl_cmd
    import ddr3_pkg::*;
#(
    parameter int unsigned DDR_FREQ_MHZ = 100,
    parameter int unsigned TREFI        = 7800,
    parameter int unsigned TRFC         = 110,
    parameter int unsigned TRCD         = 14,
    parameter int unsigned TRP          = 14,
    parameter int unsigned TWR          = 15,
    parameter int unsigned TFAW         = 40,
    parameter int unsigned ROWS         = 13
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ddl_req_i,
    output logic            ddl_rdy_o,
    output logic            ddl_ref_o,
    input  logic [2:0]      ddl_cmd_i,
    input  logic [2:0]      ddl_ba_i,
    input  logic [ROWS-1:0] ddl_adr_i,
    output logic            dfi_cs_no,
    output logic            dfi_ras_no,
    output logic            dfi_cas_no,
    output logic            dfi_we_no,
    output logic [2:0]      dfi_ba_o,
    output logic [ROWS-1:0] dfi_adr_o
);

    localparam int unsigned RSB    = ROWS - 1;
    localparam int unsigned WAIT_W = 10;

    localparam logic [WAIT_W-1:0] LD_ACTV = WAIT_W'(cycles(TRCD, DDR_FREQ_MHZ) - 1);
    localparam logic [WAIT_W-1:0] LD_PREC = WAIT_W'(cycles(TRP, DDR_FREQ_MHZ) - 1);
    localparam logic [WAIT_W-1:0] LD_REFR = WAIT_W'(cycles(TRFC, DDR_FREQ_MHZ) - 1);
    localparam logic [WAIT_W-1:0] LD_READ = WAIT_W'(DDR3_TCCD - 1);
    localparam logic [WAIT_W-1:0] LD_WRIT =
        WAIT_W'(DDR3_CWL + DDR3_BL / 2 + cycles(TWR, DDR_FREQ_MHZ) - 1);
    localparam logic [WAIT_W-1:0] LD_MODE = WAIT_W'(DDR3_TMRD - 1);
    localparam logic [WAIT_W-1:0] LD_ZQCL = WAIT_W'(DDR3_TZQCL - 1);

    ddl_state_e        state_q;
    logic              rdy_q;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] ld;
    logic              accept;
    logic              faw_block;

    assign ddl_rdy_o = rdy_q & ~faw_block;
    assign accept    = ddl_req_i & ddl_rdy_o;

    always_comb begin
        ld = '0;
        case (ddl_cmd_i)
            DDR3_ACTV: ld = LD_ACTV;
            DDR3_PREC: ld = LD_PREC;
            DDR3_REFR: ld = LD_REFR;
            DDR3_READ: ld = LD_READ;
            DDR3_WRIT: ld = LD_WRIT;
            DDR3_MODE: ld = LD_MODE;
            DDR3_ZQCL: ld = LD_ZQCL;
            default:   ld = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            rdy_q      <= 1'b0;
            wait_q     <= '0;
            dfi_cs_no  <= 1'b1;
            dfi_ras_no <= 1'b1;
            dfi_cas_no <= 1'b1;
            dfi_we_no  <= 1'b1;
            dfi_ba_o   <= 3'd0;
            dfi_adr_o  <= '0;
        end else begin
            {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no} <= 4'hf;
            if (accept && ddl_cmd_i != DDR3_NOOP) begin
                {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no} <= {1'b0, ddl_cmd_i};
                dfi_ba_o  <= ddl_ba_i;
                dfi_adr_o <= ddl_adr_i[RSB:0];
            end
            case (state_q)
                ST_INIT: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b1;
                end
                ST_IDLE: begin
                    if (accept && ld != '0) begin
                        state_q <= ST_WAIT;
                        rdy_q   <= 1'b0;
                        wait_q  <= ld;
                    end
                end
                ST_WAIT: begin
                    // Ready stays low for exactly the loaded number of cycles
                    wait_q <= wait_q - 1'b1;
                    if (wait_q <= 1) begin
                        state_q <= ST_IDLE;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef DDR3_TFAW_EN
    localparam int unsigned FAW_W = 8;
    localparam logic [FAW_W-1:0] FAW_LD = FAW_W'(cycles(TFAW, DDR_FREQ_MHZ) - 1);

    // Each entry holds the cycles left in the window of one recent ACTIVATE; [3] is the oldest
    logic [3:0][FAW_W-1:0] faw_q;

    assign faw_block = (ddl_cmd_i == DDR3_ACTV) && (faw_q[3] != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            faw_q <= '0;
        end else if (accept && ddl_cmd_i == DDR3_ACTV) begin
            faw_q[0] <= FAW_LD;
            for (int i = 1; i < 4; i++) begin
                faw_q[i] <= (faw_q[i-1] != '0) ? faw_q[i-1] - 1'b1 : '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                faw_q[i] <= (faw_q[i] != '0) ? faw_q[i] - 1'b1 : '0;
            end
        end
    end
`else
    assign faw_block = 1'b0;
`endif

    ddr3_ref_timer #(
        .INTERVAL(cycles(TREFI, DDR_FREQ_MHZ))
    ) u_ref_timer (
        .clock     (clock),
        .reset     (reset),
        .ref_done_i(accept && ddl_cmd_i == DDR3_REFR),
        .ref_req_o (ddl_ref_o)
    );

endmodule

// File: tb/tb_ddr3_ddl_cmd.sv
// Directed self-checking bench for ddr3_ddl_cmd at 100 MHz (tCK = 10 ns).
module tb_ddr3_ddl_cmd;
    import ddr3_pkg::*;

`ifdef DDR3_TFAW_EN
    localparam int unsigned TB_TRCD       = 10;
    localparam int          EXP_ACT_STALL = 0;
`else
    localparam int unsigned TB_TRCD       = 14;
    localparam int          EXP_ACT_STALL = 1;
`endif
    localparam int SEND_LIMIT = 2000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req   = 1'b0;
    logic [2:0]  cmd   = 3'b111;
    logic [2:0]  ba    = 3'd0;
    logic [12:0] adr   = 13'd0;
    logic        rdy, refp, cs_n, ras_n, cas_n, we_n;
    logic [2:0]  dba;
    logic [12:0] dadr;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int st, t0;

    ddr3_ddl_cmd #(
        .TRCD(TB_TRCD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ddl_req_i (req),
        .ddl_rdy_o (rdy),
        .ddl_ref_o (refp),
        .ddl_cmd_i (cmd),
        .ddl_ba_i  (ba),
        .ddl_adr_i (adr),
        .dfi_cs_no (cs_n),
        .dfi_ras_no(ras_n),
        .dfi_cas_no(cas_n),
        .dfi_we_no (we_n),
        .dfi_ba_o  (dba),
        .dfi_adr_o (dadr)
    );

    always #5 clock = ~clock;

    // Rising edges since the last reset release
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] pins();
        return {cs_n, ras_n, cas_n, we_n};
    endfunction

    // Hold a request until accepted; returns at the negedge after the accepting edge
    task automatic send(input logic [2:0] c, input logic [2:0] b, input logic [12:0] a,
                        output int stall);
        stall = 0;
        req = 1'b1; cmd = c; ba = b; adr = a;
        #1;
        while (!rdy && stall < SEND_LIMIT) begin
            @(negedge clock);
            stall++;
            #1;
        end
        if (stall >= SEND_LIMIT) check("send_timeout", {31'd0, rdy}, 32'd1);
        @(negedge clock);
        req = 1'b0; cmd = 3'b111;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clock);
        check("at_cyc", cyc, n);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_rdy", {31'd0, rdy}, 32'd0);
        check("rst_ref", {31'd0, refp}, 32'd0);
        check("rst_pins", {28'd0, pins()}, 32'hf);
        check("rst_ba", {29'd0, dba}, 32'd0);
        check("rst_adr", {19'd0, dadr}, 32'd0);
        @(negedge clock);
        check("init_rdy", {31'd0, rdy}, 32'd1);

        wait_cyc(779);
        check("ref_779", {31'd0, refp}, 32'd0);
        wait_cyc(780);
        check("ref_780", {31'd0, refp}, 32'd1);

        send(DDR3_ACTV, 3'd1, 13'h123, st);
        t0 = cyc;
        check("actv_stall", st, 0);
        check("actv_pins", {28'd0, pins()}, 32'h3);
        check("actv_ba", {29'd0, dba}, 32'd1);
        check("actv_adr", {19'd0, dadr}, 32'h123);
        send(DDR3_READ, 3'd1, 13'h040, st);
        check("read_stall", st, EXP_ACT_STALL);
        check("trcd_gap", cyc - t0, EXP_ACT_STALL + 1);
        check("read_pins", {28'd0, pins()}, 32'h5);
        check("read_adr", {19'd0, dadr}, 32'h040);
        @(negedge clock);
        check("noop_pins", {28'd0, pins()}, 32'hf);
        check("hold_ba", {29'd0, dba}, 32'd1);
        check("hold_adr", {19'd0, dadr}, 32'h040);

        send(DDR3_WRIT, 3'd2, 13'h0aa, st);
        t0 = cyc;
        check("writ_stall", st, 2);
        check("writ_pins", {28'd0, pins()}, 32'h4);
        send(DDR3_PREC, 3'd2, 13'h400, st);
        check("prec_stall", st, 11);
        check("twr_gap", cyc - t0, 12);
        check("prec_pins", {28'd0, pins()}, 32'h2);
        send(DDR3_MODE, 3'd3, 13'h0b30, st);
        check("mode_stall", st, 1);
        check("mode_pins", {28'd0, pins()}, 32'h0);
        send(DDR3_ZQCL, 3'd0, 13'h400, st);
        check("zqcl_stall", st, 3);
        check("zqcl_pins", {28'd0, pins()}, 32'h6);
        send(DDR3_NOOP, 3'd5, 13'h1fff, st);
        check("noop_stall", st, 511);
        check("noop_cs", {31'd0, cs_n}, 32'd1);
        check("noop_ba", {29'd0, dba}, 32'd0);
        check("noop_adr", {19'd0, dadr}, 32'h400);
        send(DDR3_NOOP, 3'd5, 13'h1fff, st);
        check("noop_no_timer", st, 0);
        check("ref_pending", {31'd0, refp}, 32'd1);

        // Asynchronous reset while a WRIT is on the pins and the wait timer is loaded
        send(DDR3_WRIT, 3'd6, 13'h077, st);
        check("writ2_pins", {28'd0, pins()}, 32'h4);
        reset = 1'b1;
        #1;
        check("arst_pins", {28'd0, pins()}, 32'hf);
        check("arst_rdy", {31'd0, rdy}, 32'd0);
        check("arst_ref", {31'd0, refp}, 32'd0);
        check("arst_ba", {29'd0, dba}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("arst_rdy_back", {31'd0, rdy}, 32'd1);

`ifdef DDR3_TFAW_EN
        for (int i = 0; i < 5; i++) begin
            send(DDR3_ACTV, 3'(i), 13'h010, st);
            if (i == 0) t0 = cyc;
            check("faw_stall", st, 0);
            check("faw_ba", {29'd0, dba}, i);
        end
        check("faw_gap", cyc - t0, 4);
`endif

        // REFR accepted on the same edge as the second interval tick
        wait_cyc(1559);
        check("pre_tick_rdy", {31'd0, rdy}, 32'd1);
        check("pre_tick_ref", {31'd0, refp}, 32'd1);
        send(DDR3_REFR, 3'd0, 13'd0, st);
        check("tick_refr_at", cyc, 1560);
        check("tick_refr_ref", {31'd0, refp}, 32'd1);
        send(DDR3_REFR, 3'd0, 13'd0, st);
        check("refr_stall", st, 10);
        check("refr_clear", {31'd0, refp}, 32'd0);

        // Nine ticks (2340..8580) with no refresh issued saturate the pending count at 8
        wait_cyc(8581);
        for (int i = 0; i < 8; i++) begin
            send(DDR3_REFR, 3'd0, 13'd0, st);
            check("sat_stall", st, (i == 0) ? 0 : 10);
            check("sat_ref", {31'd0, refp}, (i < 7) ? 32'd1 : 32'd0);
        end
        send(DDR3_REFR, 3'd0, 13'd0, st);
        check("floor_ref", {31'd0, refp}, 32'd0);
        wait_cyc(9360);
        check("floor_tick_ref", {31'd0, refp}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
